fp_align_shifter_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter for FPU mantissa alignment and normalisation.
- Successor to the fixed 28-bit combinational logical right shifter.
- Adds configurable width, three shift modes and a sticky / shifted-out flag.
- Adds a two-stage registered datapath with valid/ready backpressure and a passthrough tag. Sits between the exponent-compare stage and the mantissa adder, and before the rounder.

---
 rtl/fp_align_shifter_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fp_align_shifter_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_shifter_pipe.sv
// Two-stage pipelined barrel shifter for FPU mantissa alignment/normalisation.
// Stage 1 applies shift bits [1:0]; stage 2 applies the rest, saturation and sticky.
module fp_align_shifter_pipe #(
  parameter int WIDTH   = 28,
  parameter int SHAMT_W = 8,
  parameter int TAG_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_val,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_val,
  output logic               o_sticky,
  output logic [TAG_W-1:0]   o_tag
);

  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam int unsigned      W_U   = WIDTH;
  localparam logic [1:0]       M_LSR = 2'b00;
  localparam logic [1:0]       M_ASR = 2'b01;
  localparam logic [1:0]       M_LSL = 2'b10;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_val_q, s1_val_d;
  logic               s1_sticky_q, s1_sticky_d;
  logic [1:0]         s1_mode_q, s1_mode_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_sat_q, s1_sat_d;
  logic               s1_any_q, s1_any_d;
  logic               s1_sign_q, s1_sign_d;

  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   s2_val_q, s2_val_d;
  logic               s2_sticky_q, s2_sticky_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic               s1_load, s2_load, accept;
  logic [1:0]         lo_amt;
  logic [SHAMT_W-1:0] hi_amt;
  logic [WIDTH-1:0]   st1_val, st2_val;
  logic               st1_sticky, st2_sticky;

  always_comb begin
    s2_load = !s2_valid_q || i_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = i_valid && s1_load;
  end

  assign o_ready  = s1_load;
  assign o_valid  = s2_valid_q;
  assign o_val    = s2_val_q;
  assign o_sticky = s2_sticky_q;
  assign o_tag    = s2_tag_q;

  // Low barrel levels (0..3 positions) on the incoming operand.
  always_comb begin
    lo_amt     = i_shamt[1:0];
    st1_val    = i_val;
    st1_sticky = 1'b0;
    case (i_mode)
      M_LSR: begin
        st1_val    = i_val >> lo_amt;
        st1_sticky = |(i_val & ~(ONES << lo_amt));
      end
      M_ASR: begin
        st1_val    = (i_val >> lo_amt) | (i_val[WIDTH-1] ? ~(ONES >> lo_amt) : '0);
        st1_sticky = |(i_val & ~(ONES << lo_amt));
      end
      M_LSL: begin
        st1_val    = i_val << lo_amt;
        st1_sticky = |(i_val & ~(ONES >> lo_amt));
      end
      default: begin
        st1_val    = i_val;
        st1_sticky = 1'b0;
      end
    endcase
  end

  // Remaining levels; hi_amt is always < WIDTH unless saturating.
  always_comb begin
    hi_amt     = s1_shamt_q;
    st2_val    = s1_val_q;
    st2_sticky = 1'b0;
    case (s1_mode_q)
      M_LSR: begin
        if (s1_sat_q) begin
          st2_val    = '0;
          st2_sticky = s1_any_q;
        end else begin
          st2_val    = s1_val_q >> hi_amt;
          st2_sticky = s1_sticky_q | (|(s1_val_q & ~(ONES << hi_amt)));
        end
      end
      M_ASR: begin
        if (s1_sat_q) begin
          st2_val    = {WIDTH{s1_sign_q}};
          st2_sticky = s1_any_q;
        end else begin
          st2_val    = (s1_val_q >> hi_amt) | (s1_sign_q ? ~(ONES >> hi_amt) : '0);
          st2_sticky = s1_sticky_q | (|(s1_val_q & ~(ONES << hi_amt)));
        end
      end
      M_LSL: begin
        if (s1_sat_q) begin
          st2_val    = '0;
          st2_sticky = s1_any_q;
        end else begin
          st2_val    = s1_val_q << hi_amt;
          st2_sticky = s1_sticky_q | (|(s1_val_q & ~(ONES >> hi_amt)));
        end
      end
      default: begin
        st2_val    = s1_val_q;
        st2_sticky = 1'b0;
      end
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_val_d    = s1_val_q;
    s1_sticky_d = s1_sticky_q;
    s1_mode_d   = s1_mode_q;
    s1_shamt_d  = s1_shamt_q;
    s1_tag_d    = s1_tag_q;
    s1_sat_d    = s1_sat_q;
    s1_any_d    = s1_any_q;
    s1_sign_d   = s1_sign_q;
    s2_valid_d  = s2_valid_q;
    s2_val_d    = s2_val_q;
    s2_sticky_d = s2_sticky_q;
    s2_tag_d    = s2_tag_q;

    if (s1_load) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_val_d    = st1_val;
      s1_sticky_d = st1_sticky;
      s1_mode_d   = i_mode;
      s1_shamt_d  = {i_shamt[SHAMT_W-1:2], 2'b00};
      s1_tag_d    = i_tag;
      s1_sat_d    = (32'(i_shamt) >= W_U);
      s1_any_d    = |i_val;
      s1_sign_d   = i_val[WIDTH-1];
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_val_d    = st2_val;
        s2_sticky_d = st2_sticky;
        s2_tag_d    = s1_tag_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_sticky_q <= 1'b0;
      s1_mode_q   <= '0;
      s1_shamt_q  <= '0;
      s1_tag_q    <= '0;
      s1_sat_q    <= 1'b0;
      s1_any_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_val_q    <= '0;
      s2_sticky_q <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_sticky_q <= s1_sticky_d;
      s1_mode_q   <= s1_mode_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_tag_q    <= s1_tag_d;
      s1_sat_q    <= s1_sat_d;
      s1_any_q    <= s1_any_d;
      s1_sign_q   <= s1_sign_d;
      s2_valid_q  <= s2_valid_d;
      s2_val_q    <= s2_val_d;
      s2_sticky_q <= s2_sticky_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

endmodule

// File: tb/tb_fp_align_shifter_pipe.sv
// Directed bench for fp_align_shifter_pipe: bit-loop reference model feeding a
// queue scoreboard, plus handshake, stall and flush checks.
module tb_fp_align_shifter_pipe;
  localparam int W  = 28;
  localparam int SW = 8;
  localparam int TW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_val;
  logic [SW-1:0] i_shamt;
  logic [1:0]    i_mode;
  logic [TW-1:0] i_tag;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_val;
  logic          o_sticky;
  logic [TW-1:0] o_tag;

  fp_align_shifter_pipe #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_val   (i_val),
    .i_shamt (i_shamt),
    .i_mode  (i_mode),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_val   (o_val),
    .o_sticky(o_sticky),
    .o_tag   (o_tag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [W-1:0]  val;
    logic          sticky;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
  endtask

  // Reference: per-bit source selection, independent of any barrel structure.
  function automatic exp_t model(input logic [W-1:0] v, input int sh,
                                 input logic [1:0] m, input logic [TW-1:0] t);
    exp_t r;
    r.tag    = t;
    r.val    = '0;
    r.sticky = 1'b0;
    if (m == 2'b00 || m == 2'b01) begin
      for (int i = 0; i < W; i++)
        r.val[i] = (i + sh < W) ? v[i + sh] : ((m == 2'b01) ? v[W-1] : 1'b0);
      for (int j = 0; j < W; j++)
        if (j < sh) r.sticky = r.sticky | v[j];
    end else if (m == 2'b10) begin
      for (int i = 0; i < W; i++)
        if (i >= sh) r.val[i] = v[i - sh];
      for (int j = 0; j < W; j++)
        if (j >= W - sh) r.sticky = r.sticky | v[j];
    end else begin
      r.val = v;
    end
    return r;
  endfunction

  // One clock: score outputs and record accepts at the falling edge, then
  // advance to just after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge i_clk);
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        check("spurious_output", {63'b0, o_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("o_val", {36'b0, o_val}, {36'b0, e.val});
        check("o_sticky", {63'b0, o_sticky}, {63'b0, e.sticky});
        check("o_tag", {60'b0, o_tag}, {60'b0, e.tag});
      end
    end
    if (i_valid && o_ready && !i_rst)
      sb.push_back(model(i_val, int'(i_shamt), i_mode, i_tag));
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] v, input logic [SW-1:0] sh,
                       input logic [1:0] m, input logic [TW-1:0] t);
    i_valid = 1'b1;
    i_val   = v;
    i_shamt = sh;
    i_mode  = m;
    i_tag   = t;
  endtask

  initial begin
    exp_t head;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_val   = '0;
    i_shamt = '0;
    i_mode  = '0;
    i_tag   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    check("rst_o_valid", {63'b0, o_valid}, 64'd0);
    check("rst_o_ready", {63'b0, o_ready}, 64'd1);
    check("rst_o_val", {36'b0, o_val}, 64'd0);
    check("rst_o_sticky", {63'b0, o_sticky}, 64'd0);
    check("rst_o_tag", {60'b0, o_tag}, 64'd0);

    // Two-cycle latency on an idle pipe.
    issue(28'h8000001, 8'd1, 2'b00, 4'h3);
    cycle();
    i_valid = 1'b0;
    check("lat_not_yet", {63'b0, o_valid}, 64'd0);
    cycle();
    check("lat_valid", {63'b0, o_valid}, 64'd1);
    check("lat_tag", {60'b0, o_tag}, 64'h3);
    cycle();

    // Directed vectors: arithmetic fill, saturation, left shift, edges.
    issue(28'hF000000, 8'd4,   2'b01, 4'h1); cycle();
    issue(28'hF000000, 8'd200, 2'b01, 4'h2); cycle();
    issue(28'h1234567, 8'd4,   2'b10, 4'h3); cycle();
    issue(28'h0000000, 8'd28,  2'b00, 4'h4); cycle();
    issue(28'h0000001, 8'd28,  2'b00, 4'h5); cycle();
    issue(28'h8000000, 8'd27,  2'b10, 4'h6); cycle();
    issue(28'h0000003, 8'd28,  2'b10, 4'h7); cycle();
    issue(28'hABCDEF1, 8'd0,   2'b00, 4'h8); cycle();
    issue(28'hABCDEF1, 8'd9,   2'b11, 4'h9); cycle();
    issue(28'h7FFFFFF, 8'd255, 2'b01, 4'hA); cycle();
    issue(28'h8000000, 8'd27,  2'b01, 4'hB); cycle();
    issue(28'h0F0F0F0, 8'd13,  2'b00, 4'hC); cycle();
    i_valid = 1'b0;
    repeat (3) cycle();
    check("directed_drain", 64'(sb.size()), 64'd0);

    // Back-to-back burst of 8 at full rate.
    for (int k = 0; k < 8; k++) begin
      issue(W'($urandom), SW'($urandom_range(0, 40)), 2'(k % 3), TW'(k));
      check("burst_o_ready", {63'b0, o_ready}, 64'd1);
      cycle();
    end
    i_valid = 1'b0;
    repeat (2) cycle();
    check("burst_drain", 64'(sb.size()), 64'd0);

    // Stall for five cycles during a burst of three.
    i_ready = 1'b0;
    issue(28'h1234567, 8'd5, 2'b00, 4'hA);
    check("stall_rdy_a", {63'b0, o_ready}, 64'd1);
    cycle();
    issue(28'hFEDCBA9, 8'd3, 2'b01, 4'hB);
    check("stall_rdy_b", {63'b0, o_ready}, 64'd1);
    cycle();
    check("stall_rdy_full", {63'b0, o_ready}, 64'd0);
    issue(28'h00000FF, 8'd6, 2'b10, 4'hC);
    head = sb[0];
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_o_ready", {63'b0, o_ready}, 64'd0);
      check("stall_o_valid", {63'b0, o_valid}, 64'd1);
      check("stall_o_val", {36'b0, o_val}, {36'b0, head.val});
      check("stall_o_sticky", {63'b0, o_sticky}, {63'b0, head.sticky});
      check("stall_o_tag", {60'b0, o_tag}, {60'b0, head.tag});
    end
    i_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (4) cycle();
    check("stall_drain", 64'(sb.size()), 64'd0);

    // Flush with both stages full.
    i_ready = 1'b0;
    issue(28'h0000F00, 8'd2, 2'b00, 4'hD); cycle();
    issue(28'h0000F00, 8'd3, 2'b00, 4'hE); cycle();
    check("flush_full_rdy", {63'b0, o_ready}, 64'd0);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    cycle();
    i_rst = 1'b0;
    check("flush_o_valid", {63'b0, o_valid}, 64'd0);
    check("flush_o_ready", {63'b0, o_ready}, 64'd1);
    sb.delete();
    i_ready = 1'b1;
    issue(28'h0000100, 8'd8, 2'b00, 4'h9);
    cycle();
    i_valid = 1'b0;
    cycle();
    check("post_flush_valid", {63'b0, o_valid}, 64'd1);
    check("post_flush_tag", {60'b0, o_tag}, 64'h9);
    repeat (4) cycle();
    check("post_flush_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
